// File: rtl/tx_arbiter_pkg.sv
// tx_arbiter_pkg: FSM state type and default timing parameters for tx_arbiter.
package tx_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;
    localparam int DEF_GAP_CYCLES = 16;
    localparam int DEF_START_TIMEOUT = 8;
endpackage

// File: rtl/tx_arbiter_rr.sv
// rr_select: combinational round-robin pick of the first request after i_last.
// Ports: i_req request vector, i_last last granted index,
//        o_gnt chosen index, o_gnt_valid any request present.
module rr_select #(
    parameter int NUM_REQ = 4,
    localparam int W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [W-1:0]       i_last,
    output logic [W-1:0]       o_gnt,
    output logic               o_gnt_valid
);
    logic [W-1:0] w_idx;
    // Walk the search order backwards so the nearest candidate after i_last wins.
    always_comb begin
        o_gnt = '0;
        o_gnt_valid = 1'b0;
        w_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = W'((int'(i_last) + k) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_gnt = w_idx;
                o_gnt_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter feeding one byte at a time to a UART transmitter.
// Ports: clk/rst (sync, active high); req_valid/req_data/req_ready requester side;
//        tx_send/tx_din/tx_busy transmitter side; grant_id, active, start_err status.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    localparam int W = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_send,
    output logic [7:0]           tx_din,
    input  logic                 tx_busy,
    output logic [W-1:0]         grant_id,
    output logic                 active,
    output logic                 start_err
);
    localparam logic [15:0] TO_LAST = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    state_t             r_state;
    logic [NUM_REQ-1:0] r_req_ready;
    logic               r_tx_send;
    logic [7:0]         r_tx_din;
    logic [W-1:0]       r_grant_id;
    logic [W-1:0]       r_rr_last;
    logic               r_start_err;
    logic [15:0]        r_cnt;
    logic [W-1:0]       w_gnt;
    logic               w_gnt_valid;
    logic [7:0]         w_byte;
    logic               w_to_done;
    logic               w_gap_done;
    // r_rr_last resets to the top index so the first search begins at requester 0.
    rr_select #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req       (req_valid),
        .i_last      (r_rr_last),
        .o_gnt       (w_gnt),
        .o_gnt_valid (w_gnt_valid)
    );
    always_comb begin
        w_byte = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (w_gnt == W'(i)) w_byte = req_data[8*i +: 8];
    end
    assign w_to_done = r_cnt == TO_LAST;
    // A zero gap still spends one cycle in GAP.
    assign w_gap_done = (GAP_CYCLES == 0) || (r_cnt == GAP_LAST);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_req_ready <= '0;
            r_tx_send <= 1'b0;
            r_tx_din <= '0;
            r_grant_id <= '0;
            r_rr_last <= W'(NUM_REQ - 1);
            r_start_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_req_ready <= '0;
            r_start_err <= 1'b0;
            case (r_state)
                IDLE: if (w_gnt_valid && !tx_busy) begin
                    r_req_ready <= NUM_REQ'(1) << w_gnt;
                    r_tx_din <= w_byte;
                    r_grant_id <= w_gnt;
                    r_rr_last <= w_gnt;
                    r_state <= START;
                end
                START: begin
                    r_tx_send <= 1'b1;
                    r_cnt <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: if (tx_busy) begin
                    r_tx_send <= 1'b0;
                    r_state <= WAIT_DONE;
                end else if (w_to_done) begin
                    r_tx_send <= 1'b0;
                    r_start_err <= 1'b1;
                    r_cnt <= '0;
                    r_state <= GAP;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
                WAIT_DONE: if (!tx_busy) begin
                    r_cnt <= '0;
                    r_state <= GAP;
                end
                GAP: if (w_gap_done) begin
                    r_cnt <= '0;
                    r_state <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign req_ready = r_req_ready;
    assign tx_send = r_tx_send;
    assign tx_din = r_tx_din;
    assign grant_id = r_grant_id;
    assign start_err = r_start_err;
    assign active = r_state != IDLE;
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed self-checking bench for tx_arbiter with default parameters.
module tb_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_send;
    logic [7:0]  tx_din;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        start_err;
    int n_tests = 0;
    int n_fail = 0;
    tx_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_send   (tx_send),
        .tx_din    (tx_din),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active),
        .start_err (start_err)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_din", tx_din, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_active", active, 0);
        chk("rst_start_err", start_err, 0);
    endtask
    // One complete frame with a cooperative transmitter: grant, send, busy, gap.
    task automatic run_frame(input logic [3:0] exp_rdy, input logic [7:0] exp_din,
                             input logic [1:0] exp_id, input logic [3:0] clr);
        int n = 0;
        while (req_ready == 4'b0 && n < 40) begin
            step();
            n++;
        end
        chk("grant_latency", n, 1);
        chk("req_ready", req_ready, exp_rdy);
        chk("grant_id", grant_id, exp_id);
        chk("tx_din_latch", tx_din, exp_din);
        chk("send_before_ready_end", tx_send, 0);
        req_valid = req_valid & ~clr;
        step();
        chk("tx_send_rise", tx_send, 1);
        chk("ready_width", req_ready, 0);
        tx_busy = 1'b1;
        step();
        chk("tx_send_drop", tx_send, 0);
        repeat (3) step();
        chk("tx_din_hold", tx_din, exp_din);
        tx_busy = 1'b0;
        step();
        repeat (15) step();
        chk("gap_active", active, 1);
        step();
        chk("gap_end", active, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        tx_busy = 1'b0;
        step();
        step();
        chk_reset_outputs();
        rst = 1'b0;
        step();
        req_data[7:0] = 8'h41;
        req_valid = 4'b0001;
        run_frame(4'b0001, 8'h41, 2'd0, 4'b0001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_data = 32'hA3A2A1A0;
        req_valid = 4'hF;
        run_frame(4'b0001, 8'hA0, 2'd0, 4'b0000);
        run_frame(4'b0010, 8'hA1, 2'd1, 4'b0000);
        run_frame(4'b0100, 8'hA2, 2'd2, 4'b0000);
        run_frame(4'b1000, 8'hA3, 2'd3, 4'b0000);
        run_frame(4'b0001, 8'hA0, 2'd0, 4'hF);
        req_valid = 4'b1000;
        run_frame(4'b1000, 8'hA3, 2'd3, 4'b1000);
        req_valid = 4'b1001;
        run_frame(4'b0001, 8'hA0, 2'd0, 4'b0001);
        run_frame(4'b1000, 8'hA3, 2'd3, 4'b1000);
        req_data[23:16] = 8'h55;
        req_valid = 4'b0100;
        step();
        chk("to_req_ready", req_ready, 4'b0100);
        req_valid = '0;
        req_data[23:16] = 8'hEE;
        step();
        chk("to_tx_send", tx_send, 1);
        chk("to_din_latched", tx_din, 8'h55);
        repeat (7) step();
        chk("to_send_held", tx_send, 1);
        chk("to_no_err_early", start_err, 0);
        step();
        chk("to_start_err", start_err, 1);
        chk("to_send_drop", tx_send, 0);
        step();
        chk("to_err_width", start_err, 0);
        repeat (14) step();
        chk("to_gap_active", active, 1);
        step();
        chk("to_gap_end", active, 0);
        req_data[15:8] = 8'h66;
        req_valid = 4'b0010;
        run_frame(4'b0010, 8'h66, 2'd1, 4'b0010);
        req_data[23:16] = 8'h77;
        req_valid = 4'b0100;
        step();
        chk("mid_req_ready", req_ready, 4'b0100);
        req_valid = '0;
        step();
        tx_busy = 1'b1;
        step();
        req_data[15:8] = 8'h11;
        req_data[31:24] = 8'h33;
        req_valid = 4'b1010;
        step();
        step();
        chk("mid_active", active, 1);
        rst = 1'b1;
        step();
        chk_reset_outputs();
        rst = 1'b0;
        step();
        chk("busy_no_grant", req_ready, 0);
        step();
        chk("busy_idle", active, 0);
        tx_busy = 1'b0;
        run_frame(4'b0010, 8'h11, 2'd1, 4'b0010);
        run_frame(4'b1000, 8'h33, 2'd3, 4'b1000);
        tx_busy = 1'b1;
        req_valid = 4'b0010;
        step();
        step();
        step();
        chk("busy2_no_grant", req_ready, 0);
        chk("busy2_idle", active, 0);
        tx_busy = 1'b0;
        run_frame(4'b0010, 8'h11, 2'd1, 4'b0010);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters sharing one UART transmitter (2..8).
REQ-002 Parameter GAP_CYCLES, default 16: idle clocks enforced between frames (0..65535).
REQ-003 Parameter START_TIMEOUT, default 8: clocks allowed for tx_busy to rise after tx_send is asserted.
REQ-004 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port req_valid  input  NUM_REQ  per-requester byte pending.
REQ-007 Port req_data  input  NUM_REQ*8  requester i byte at bits [8i+7:8i].
REQ-008 Port req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-009 Port tx_send  output  1  start request to the UART transmitter.
REQ-010 Port tx_din  output  8  byte to transmit; stable while tx_send is high and while tx_busy is high.
REQ-011 Port tx_busy  input  1  transmitter busy flag.
REQ-012 Port grant_id  output  $clog2(NUM_REQ)  index of the requester owning the current or last frame.
REQ-013 Port active  output  1  high in every state except IDLE.
REQ-014 Port start_err  output  1  one-cycle pulse when START_TIMEOUT expires.

Function
REQ-015 The FSM shall have states IDLE, START, WAIT_BUSY, WAIT_DONE and GAP.
REQ-016 IDLE: when any req_valid is high and tx_busy is low, grant one requester by round-robin, latch its byte into tx_din, pulse its req_ready for that single cycle, set grant_id, and go to START.
REQ-017 Round-robin shall search from (last grant_id + 1) mod NUM_REQ upward with wrap; after reset the search starts at index 0.
REQ-018 A requester shall hold req_valid and req_data until its req_ready pulse; the data is captured on the req_ready cycle, and a later change has no effect.
REQ-019 START: drive tx_send high for exactly one cycle, then go to WAIT_BUSY.
REQ-020 WAIT_BUSY: hold tx_send high; when tx_busy is high, drop tx_send and go to WAIT_DONE; after START_TIMEOUT cycles without tx_busy, drop tx_send, pulse start_err and go to GAP.
REQ-021 WAIT_DONE: tx_send low; when tx_busy falls, go to GAP.
REQ-022 GAP: count GAP_CYCLES clocks, then go to IDLE; GAP_CYCLES=0 means GAP lasts exactly one cycle.
REQ-023 Only one req_ready bit shall be high in any cycle, and at most one per frame.
REQ-024 Requests arriving in any non-IDLE state shall wait; they are never dropped or reordered per requester.
REQ-025 If a granted requester deasserts req_valid after its req_ready pulse, the frame still completes.
REQ-026 Latency from req_valid rising in IDLE (tx_busy low) to req_ready shall be 1 cycle; req_ready to tx_send high shall be 1 cycle.

Reset
REQ-027 On rst: state IDLE, req_ready=0, tx_send=0, tx_din=0, grant_id=0, active=0, start_err=0, the timeout and gap counters cleared, and the round-robin pointer set to 0.
REQ-028 Reset asserted mid-frame shall abort immediately with no req_ready or start_err pulse, even if tx_busy is still high.

Structure
REQ-029 Package tx_arbiter_pkg shall hold the FSM state enum typedef and the default values of GAP_CYCLES and START_TIMEOUT.
REQ-030 Round-robin selection shall be a sub-module rr_select (inputs: request vector and last grant; outputs: grant index and grant-valid), purely combinational.
REQ-031 The existing tx module shall be instantiated only by the top level, not inside tx_arbiter.

Verification
REQ-032 Single request: req_valid=0001, data 0x41 -> req_ready[0] 1 cycle later, tx_send next cycle, tx_din=0x41 until tx_busy falls, then 16 GAP cycles before IDLE.
REQ-033 Contention: all four valid continuously with bytes 0xA0..0xA3 -> grant order 0,1,2,3,0 and each req_ready one cycle wide.
REQ-034 Wrap: last grant=3, requests 1001 -> requester 0 granted next, then 3.
REQ-035 Timeout: tx_busy tied low -> start_err pulses 8 cycles after tx_send rises, then GAP, and the next request is served.
REQ-036 Reset mid-frame: rst during WAIT_DONE -> next cycle all outputs at reset values; a pending request is granted from index 0 after rst falls.
REQ-037 Busy at idle: tx_busy high in IDLE with req_valid=0010 -> no grant until tx_busy low, then req_ready[1] on the following cycle.
